// File: rtl/calculate_mean_window.sv
// Sliding-window mean and detection threshold for the correlator peak-detect path.
// Optional threshold floor: define CALC_MEAN_FLOOR_EN to clamp Calc_mean to at least THR_FLOOR.
module calculate_mean_window #(
    parameter int width_Dat = 24,
    parameter int Wind_size = 128,
    parameter int KOEF_FRAC = 4,
    parameter int THR_FLOOR = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [width_Dat-1:0] data_in,
    input  logic [width_Dat-1:0] koef,
    output logic [width_Dat-1:0] data_out,
    output logic [width_Dat-1:0] Calc_mean
);

    localparam int LOG2W  = $clog2(Wind_size);
    localparam int SUM_W  = width_Dat + LOG2W;
    localparam int PROD_W = 2 * width_Dat;
    localparam int HALF   = Wind_size / 2;
    localparam logic [width_Dat-1:0] FLOOR_V  = width_Dat'(THR_FLOOR);
    localparam logic [width_Dat-1:0] ALL_ONES = '1;

`ifdef CALC_MEAN_FLOOR_EN
    localparam bit FLOOR_EN = 1'b1;
`else
    localparam bit FLOOR_EN = 1'b0;
`endif

    logic [width_Dat-1:0] dly [Wind_size];
    logic [SUM_W-1:0]     sum_r;
    logic [width_Dat-1:0] mean_r;
    logic [PROD_W-1:0]    prod;
    logic [PROD_W-1:0]    thr;
    logic [width_Dat-1:0] thr_sat;
    logic [width_Dat-1:0] calc_nxt;

    // One delay line serves both the window tail and the centre tap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < Wind_size; i++) dly[i] <= '0;
        end else begin
            dly[0] <= data_in;
            for (int i = 1; i < Wind_size; i++) dly[i] <= dly[i-1];
        end
    end

    assign data_out = dly[HALF-1];

    // Intermediate may wrap modulo 2^SUM_W, but the true result is never negative.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sum_r <= '0;
        else     sum_r <= sum_r + SUM_W'(data_in) - SUM_W'(dly[Wind_size-1]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) mean_r <= '0;
        else     mean_r <= sum_r[SUM_W-1:LOG2W];
    end

    always_comb begin
        prod     = PROD_W'(mean_r) * PROD_W'(koef);
        thr      = prod >> KOEF_FRAC;
        thr_sat  = (|thr[PROD_W-1:width_Dat]) ? ALL_ONES : thr[width_Dat-1:0];
        calc_nxt = thr_sat;
        if (FLOOR_EN && (thr_sat < FLOOR_V)) calc_nxt = FLOOR_V;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) Calc_mean <= '0;
        else     Calc_mean <= calc_nxt;
    end

endmodule

// File: tb/tb_calculate_mean_window.sv
// Bench for calculate_mean_window: window-sum scoreboard plus steady-state vector table.
module tb_calculate_mean_window;

    localparam int DW = 24;
    localparam int W  = 128;
`ifdef CALC_MEAN_FLOOR_EN
    localparam logic [DW-1:0] ZERO_THR = 24'd16;
`else
    localparam logic [DW-1:0] ZERO_THR = 24'd0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] data_in = '0;
    logic [DW-1:0] koef = '0;
    logic [DW-1:0] data_out;
    logic [DW-1:0] Calc_mean;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] hist[$];
    logic [DW-1:0] mq[$];
    logic [DW-1:0] dq[$];

    typedef struct {
        logic [DW-1:0] din;
        logic [DW-1:0] k;
        int            n;
        logic [DW-1:0] exp_cm;
        logic [DW-1:0] exp_do;
    } vec_t;
    vec_t tbl[7];

    calculate_mean_window #(.width_Dat(DW), .Wind_size(W), .KOEF_FRAC(4), .THR_FLOOR(16)) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .koef(koef),
        .data_out(data_out), .Calc_mean(Calc_mean)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] exp_thr(input logic [DW-1:0] m, input logic [DW-1:0] k);
        longint unsigned p;
        logic [DW-1:0]   r;
        p = (longint'(m) * longint'(k)) >> 4;
        r = (p > 64'h00FF_FFFF) ? 24'hFF_FFFF : p[DW-1:0];
`ifdef CALC_MEAN_FLOOR_EN
        if (r < 24'd16) r = 24'd16;
`endif
        return r;
    endfunction

    task automatic mdl_reset();
        hist.delete();
        mq.delete();
        dq.delete();
        repeat (2) mq.push_back('0);
        repeat (W/2 - 1) dq.push_back('0);
    endtask

    // Drive one sample, clock it in, then check the scoreboard heads that are due now.
    task automatic step(input logic [DW-1:0] d, input logic [DW-1:0] k);
        longint unsigned s;
        logic [DW-1:0]   em, ed;
        data_in = d;
        koef    = k;
        hist.push_front(d);
        if (hist.size() > W) void'(hist.pop_back());
        s = 0;
        foreach (hist[i]) s += hist[i];
        mq.push_back(DW'(s / W));
        dq.push_back(d);
        @(posedge clk);
        #1;
        em = mq.pop_front();
        ed = dq.pop_front();
        chk("calc_mean_sb", 32'(Calc_mean), 32'(exp_thr(em, k)));
        chk("data_out_sb", 32'(data_out), 32'(ed));
    endtask

    task automatic ramp_1000();
        for (int i = 1; i <= 128; i++) step(24'd1000, 24'd16);
        step(24'd1000, 24'd16);
        chk("ramp_edge129", 32'(Calc_mean), 32'd992);
        step(24'd1000, 24'd16);
        chk("ramp_edge130", 32'(Calc_mean), 32'd1000);
        chk("ramp_data_out", 32'(data_out), 32'd1000);
    endtask

    initial begin
        int n_cm, first_cm, n_do, pos_do;
        tbl[0] = '{24'd1000,   24'd16,     100, 24'd1000,   24'd1000};
        tbl[1] = '{24'd1000,   24'd40,     5,   24'd2500,   24'd1000};
        tbl[2] = '{24'd1000,   24'd8,      1,   24'd500,    24'd1000};
        tbl[3] = '{24'hFFFFFF, 24'hFFFFFF, 200, 24'hFFFFFF, 24'hFFFFFF};
        tbl[4] = '{24'hFFFFFF, 24'd8,      3,   24'h7FFFFF, 24'hFFFFFF};
        tbl[5] = '{24'h00007F, 24'd32,     200, 24'h0000FE, 24'h00007F};
        tbl[6] = '{24'd0,      24'd16,     200, ZERO_THR,   24'd0};

        mdl_reset();
        #12;
        chk("reset_data_out", 32'(data_out), 32'd0);
        chk("reset_calc_mean", 32'(Calc_mean), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        ramp_1000();

        foreach (tbl[r]) begin
            for (int c = 0; c < tbl[r].n; c++) step(tbl[r].din, tbl[r].k);
            chk($sformatf("tbl%0d_calc_mean", r), 32'(Calc_mean), 32'(tbl[r].exp_cm));
            chk($sformatf("tbl%0d_data_out", r), 32'(data_out), 32'(tbl[r].exp_do));
        end

        // Single impulse among zeros.
        step(24'd12800, 24'd16);
        n_cm = 0; first_cm = -1; n_do = 0; pos_do = -1;
        for (int j = 1; j <= 200; j++) begin
            step(24'd0, 24'd16);
            if (Calc_mean == 24'd100) begin
                n_cm++;
                if (first_cm < 0) first_cm = j;
            end
            if (data_out == 24'd12800) begin
                n_do++;
                pos_do = j;
            end
        end
        chk("impulse_cm_count", 32'(n_cm), 32'd128);
        chk("impulse_cm_first", 32'(first_cm), 32'd2);
        chk("impulse_do_count", 32'(n_do), 32'd1);
        chk("impulse_do_pos", 32'(pos_do), 32'd63);

        // Reset pulse landing between clock edges.
        for (int j = 0; j < 80; j++) step(24'd1000, 24'd16);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_data_out", 32'(data_out), 32'd0);
        chk("midrst_calc_mean", 32'(Calc_mean), 32'd0);
        @(negedge clk);
        @(negedge clk);
        chk("midrst_hold_calc_mean", 32'(Calc_mean), 32'd0);
        rst = 1'b0;
        mdl_reset();
        ramp_1000();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
